// File: rtl/fpu_pkg.sv
// Shared floating-point definitions for the iterative fp32 arithmetic blocks.
// Holds the sequencer state encoding, IEEE-754 single constants and the unpacked-operand record.
package fpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2,
    DONE   = 2'd3
  } fsm_state_t;

  localparam int          FP_BIAS    = 127;
  localparam int          FP_EXP_MAX = 255;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam int          DIV_ITERS  = 25;

  // is_special flags an all-ones exponent (infinity or NaN).
  typedef struct packed {
    logic        sign;
    logic [8:0]  exp;
    logic [23:0] mant;
    logic        is_zero;
    logic        is_special;
  } fp_fields_t;

endpackage

// File: rtl/fdiv32_iter_if.sv
// Request/response bundle for the iterative fp32 divider.
// The master issues start with operands; the slave returns Result, busy and done.
interface fdiv32_iter_if;

  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Result;
  logic        busy;
  logic        done;

  modport master (output start, A, B, input Result, busy, done);
  modport slave  (input start, A, B, output Result, busy, done);

endinterface

// File: rtl/fp32_unpack.sv
// Splits an IEEE-754 single into sign, zero-extended exponent and mantissa with hidden bit.
// Denormals are not supported, so any zero exponent is classified as zero.
module fp32_unpack
  import fpu_pkg::*;
(
  input  logic [31:0] x,
  output fp_fields_t  f
);

  always_comb begin
    f            = '0;
    f.sign       = x[31];
    f.exp        = {1'b0, x[30:23]};
    f.mant       = {1'b1, x[22:0]};
    f.is_zero    = (x[30:23] == 8'd0);
    f.is_special = (x[30:23] == 8'(FP_EXP_MAX));
  end

endmodule

// File: rtl/fdiv32_iter.sv
// Iterative IEEE-754 single-precision divider: restoring division, one quotient bit per clock.
// Truncating, no denormal support; special operands resolve on the accepting edge.
module fdiv32_iter
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Result,
  output logic        busy,
  output logic        done
);

  fp_fields_t fa;
  fp_fields_t fb;

  fp32_unpack u_unpack_a (.x(A), .f(fa));
  fp32_unpack u_unpack_b (.x(B), .f(fb));

  fsm_state_t  state;
  logic        sign_reg;
  logic [8:0]  exp_a_reg;
  logic [8:0]  exp_b_reg;
  logic [23:0] mant_b_reg;
  logic [24:0] rem_reg;
  logic [24:0] q_reg;
  logic [4:0]  cnt_reg;

  logic        sign_in;
  logic [24:0] rem_diff;
  logic        q_bit;
  logic signed [9:0] exp_final;
  logic [22:0] frac;

  assign sign_in = fa.sign ^ fb.sign;

  // The remainder never exceeds twice the divisor, so bit 24 of the difference is the borrow.
  always_comb begin
    rem_diff = rem_reg - {1'b0, mant_b_reg};
    q_bit    = ~rem_diff[24];
  end

  always_comb begin
    exp_final = $signed({1'b0, exp_a_reg} - {1'b0, exp_b_reg} + 10'(FP_BIAS)
                        - (q_reg[24] ? 10'd0 : 10'd1));
    frac      = q_reg[24] ? q_reg[23:1] : q_reg[22:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      Result     <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      sign_reg   <= 1'b0;
      exp_a_reg  <= '0;
      exp_b_reg  <= '0;
      mant_b_reg <= '0;
      rem_reg    <= '0;
      q_reg      <= '0;
      cnt_reg    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_reg   <= sign_in;
            exp_a_reg  <= fa.exp;
            exp_b_reg  <= fb.exp;
            mant_b_reg <= fb.mant;
            rem_reg    <= {1'b0, fa.mant};
            q_reg      <= '0;
            cnt_reg    <= '0;
            busy       <= 1'b1;
            if (fa.is_special || fb.is_special || (fa.is_zero && fb.is_zero)) begin
              Result <= FP_QNAN;
              done   <= 1'b1;
              state  <= DONE;
            end else if (fb.is_zero) begin
              Result <= {sign_in, 8'(FP_EXP_MAX), 23'd0};
              done   <= 1'b1;
              state  <= DONE;
            end else if (fa.is_zero) begin
              Result <= {sign_in, 31'd0};
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state <= DIVIDE;
            end
          end
        end

        DIVIDE: begin
          rem_reg <= {(q_bit ? rem_diff[23:0] : rem_reg[23:0]), 1'b0};
          q_reg   <= {q_reg[23:0], q_bit};
          if (cnt_reg == 5'(DIV_ITERS - 1)) begin
            cnt_reg <= '0;
            state   <= NORM;
          end else begin
            cnt_reg <= cnt_reg + 5'd1;
          end
        end

        NORM: begin
          if (exp_final >= $signed(10'(FP_EXP_MAX))) begin
            Result <= {sign_reg, 8'(FP_EXP_MAX), 23'd0};
          end else if (exp_final <= 10'sd0) begin
            Result <= {sign_reg, 31'd0};
          end else begin
            Result <= {sign_reg, exp_final[7:0], frac};
          end
          done  <= 1'b1;
          state <= DONE;
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv32_iter.sv
// Directed-vector bench for fdiv32_iter: latency, quotient, special cases, reset abort, back-to-back.
module tb_fdiv32_iter;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  fdiv32_iter_if bus ();

  fdiv32_iter dut (
    .clk    (clk),
    .reset  (reset),
    .start  (bus.start),
    .A      (bus.A),
    .B      (bus.B),
    .Result (bus.Result),
    .busy   (bus.busy),
    .done   (bus.done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
    $display("vec %0d %s: observed %h expected %h", vectors, tag, obs, expv);
  endtask

  // Issue one division; poke_at > 0 pulses start with other operands while busy.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input int poke_at);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    while (!seen && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        bus.start = 1'b0;
        bus.A     = 32'h12345678;
        bus.B     = 32'h3FC00000;
        chk({tag, " busy_after_accept"}, {31'd0, bus.busy}, 32'd1);
      end
      if (poke_at > 0 && cyc == poke_at) begin
        bus.A     = 32'h3F800000;
        bus.B     = 32'h40400000;
        bus.start = 1'b1;
      end
      if (poke_at > 0 && cyc == poke_at + 1) bus.start = 1'b0;
      if (bus.done) seen = 1'b1;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, " result"}, bus.Result, exp_res);
    @(posedge clk);
    #1;
    chk({tag, " done_pulse_end"}, {31'd0, bus.done}, 32'd0);
    chk({tag, " busy_end"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int cyc;
    int first;
    int second;
    int done_hits;

    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.A       = '0;
    bus.B       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset result", bus.Result, 32'h00000000);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("6/2", 32'h40C00000, 32'h40000000, 32'h40400000, 27, 0);
    run_op("1/3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 27, 0);
    run_op("-8/0.5", 32'hC1000000, 32'h3F000000, 32'hC1800000, 27, 0);
    run_op("1/0", 32'h3F800000, 32'h00000000, 32'h7F800000, 1, 0);
    run_op("-1/0", 32'hBF800000, 32'h00000000, 32'hFF800000, 1, 0);
    run_op("0/0", 32'h00000000, 32'h00000000, 32'h7FC00000, 1, 0);
    run_op("-0/2", 32'h80000000, 32'h40000000, 32'h80000000, 1, 0);
    run_op("inf/1", 32'h7F800000, 32'h3F800000, 32'h7FC00000, 1, 0);
    run_op("overflow", 32'h7F000000, 32'h00800000, 32'h7F800000, 27, 0);
    run_op("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 27, 0);
    run_op("start_while_busy", 32'h40C00000, 32'h40000000, 32'h40400000, 27, 5);

    // Abort a division at iteration 10 with an asynchronous reset.
    @(negedge clk);
    bus.A     = 32'h40C00000;
    bus.B     = 32'h40000000;
    bus.start = 1'b1;
    repeat (11) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("abort busy", {31'd0, bus.busy}, 32'd0);
    chk("abort done", {31'd0, bus.done}, 32'd0);
    chk("abort result", bus.Result, 32'h00000000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    done_hits = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.done) done_hits++;
    end
    chk("abort no_done", 32'(done_hits), 32'd0);
    chk("abort idle_result", bus.Result, 32'h00000000);
    run_op("after_abort", 32'hC1000000, 32'h3F000000, 32'hC1800000, 27, 0);

    // Start held high through DONE: second operation accepted on the first IDLE cycle.
    @(negedge clk);
    bus.A     = 32'h40C00000;
    bus.B     = 32'h40000000;
    bus.start = 1'b1;
    cyc       = 0;
    first     = 0;
    second    = 0;
    while (second == 0 && cyc < 80) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        bus.A = 32'h3F800000;
        bus.B = 32'h40400000;
      end
      if (bus.done) begin
        if (first == 0) begin
          first = cyc;
          chk("b2b first_result", bus.Result, 32'h40400000);
        end else begin
          second = cyc;
        end
      end
    end
    bus.start = 1'b0;
    chk("b2b first_latency", 32'(first), 32'd27);
    chk("b2b spacing", 32'(second - first), 32'd28);
    chk("b2b second_result", bus.Result, 32'h3EAAAAAA);
    @(posedge clk);
    #1;
    chk("b2b busy_end", {31'd0, bus.busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fdiv32_iter.md
FDIV32_ITER -- requirements
Module: fdiv32_iter

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 SHALL have port A, input, 32 bits: IEEE-754 single-precision dividend.
REQ-005 SHALL have port B, input, 32 bits: IEEE-754 single-precision divisor.
REQ-006 SHALL have port Result, output, 32 bits: quotient, registered and held until the next accepted start.
REQ-007 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-008 SHALL have port done, output, 1 bit: single-cycle pulse marking Result valid.

Function
REQ-009 SHALL implement states IDLE, DIVIDE, NORM and DONE.
- IDLE -> DIVIDE on start=1.
- DIVIDE -> NORM after 25 iterations.
- NORM -> DONE always.
- DONE -> IDLE unconditionally.
REQ-010 SHALL, on the accepting edge, latch sign = A[31]^B[31], 9-bit zero-extended exponents, and 24-bit mantissas with hidden bit 1.
REQ-011 SHALL treat any input with exponent 0 as zero; denormals SHALL NOT be supported.
REQ-012 SHALL resolve special cases on the accepting edge, write Result directly, and go to DONE (latency 1), in this priority:
- either exponent is 255, or both inputs are zero: Result = 0x7FC00000.
- B is zero: Result = {sign, 0xFF, 0}.
- A is zero: Result = {sign, 31'b0}.
REQ-013 SHALL perform restoring division in DIVIDE, producing one quotient bit per cycle.
- Partial remainder: 25-bit register, initialised to mantissaA.
- Per cycle: subtract mantissaB if remainder >= mantissaB, shift left, shift the resulting bit into q[24:0] MSB-first.
REQ-014 SHALL use a 5-bit iteration counter, 0..24; the transition to NORM occurs on the edge performing iteration 24.
REQ-015 SHALL compute the signed 10-bit exponent expA - expB + 127 in NORM.
- If q[24]=1: fraction = q[23:1].
- Else: fraction = q[22:0] and exponent decremented by 1.
REQ-016 SHALL truncate the fraction; no rounding is performed.
REQ-017 SHALL, in NORM, give Result = {sign, 0xFF, 0} if the final exponent >= 255.
REQ-018 SHALL, in NORM, give Result = {sign, 31'b0} if the final exponent <= 0.
REQ-019 SHALL otherwise give Result = {sign, exp[7:0], fraction}.
REQ-020 SHALL assert done exactly 27 cycles after the accepting edge for normal operands (edges: accept k, iterations k+1..k+25, NORM write k+26, done high after k+26, low after k+27).
REQ-021 SHALL ignore start while busy; A and B may change freely after the accepting edge.
REQ-022 SHALL accept start=1 held through DONE on the first IDLE cycle after DONE (back-to-back throughput one result per 28 cycles).

Reset
REQ-023 SHALL force state IDLE, Result=0, done=0, busy=0, counter=0, remainder=0 and quotient=0 on reset, including mid-division; the aborted result SHALL NOT appear.

Structure
REQ-024 SHALL take the following from shared package fpu_pkg, which fmul32-class blocks also use:
- state enum.
- constants FP_BIAS=127, FP_EXP_MAX=255, FP_QNAN=32'h7FC00000, DIV_ITERS=25.
REQ-025 SHALL place field extraction and zero/inf/NaN classification in one combinational sub-module, fp32_unpack, reused for A and B.

Verification
REQ-026 SHALL cover: A=0x40C00000 (6.0), B=0x40000000 (2.0) -> Result 0x40400000, done 27 cycles after start.
REQ-027 SHALL cover: A=0x3F800000, B=0x40400000 (1/3) -> Result 0x3EAAAAAA (truncated).
REQ-028 SHALL cover: A=0xC1000000 (-8.0), B=0x3F000000 (0.5) -> Result 0xC1800000.
REQ-029 SHALL cover: A=0x3F800000, B=0x00000000 -> Result 0x7F800000, done 1 cycle after start; A=B=0 -> 0x7FC00000.
REQ-030 SHALL cover: A=0x7F000000, B=0x00800000 -> 0x7F800000 (overflow); A=0x00800000, B=0x7F000000 -> 0x00000000 (underflow).
REQ-031 SHALL cover: reset pulse at iteration 10, then a new start -> no done for the aborted operation, busy=0 immediately, the new result correct at 27 cycles; start pulses while busy ignored.
